// File: rtl/spike_rate_monitor.sv
// Spike-rate and inter-spike-interval monitor for a single neuron spike stream.
// Counts spikes over fixed windows of enabled cycles and tracks the ISI with a burst flag.
module spike_rate_monitor #(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned ISI_W       = 8,
  parameter int unsigned BURST_ISI   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear_i,
  input  logic             spike_i,
  output logic [CNT_W-1:0] rate_o,
  output logic             rate_valid_o,
  input  logic             rate_ready_i,
  output logic             overrun_o,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid_o,
  output logic             burst_o
);

  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]       scnt_q, scnt_d;
  logic [ISI_W-1:0]       icnt_q, icnt_d;
  logic                   have_prev_q, have_prev_d;
  logic [CNT_W-1:0]       rate_q, rate_d;
  logic                   rate_valid_q, rate_valid_d;
  logic                   overrun_q, overrun_d;
  logic [ISI_W-1:0]       isi_q, isi_d;
  logic                   isi_valid_q, isi_valid_d;
  logic                   burst_q, burst_d;

  logic                   xfer;
  logic [CNT_W-1:0]       scnt_sum;
  logic [ISI_W-1:0]       isi_inc;
  logic                   is_burst;

  always_comb begin
    xfer     = rate_valid_q & rate_ready_i;
    scnt_sum = (&scnt_q) ? scnt_q : scnt_q + CNT_W'(spike_i);
    // Saturating increment doubles as the interval value on a spike cycle.
    isi_inc  = (&icnt_q) ? icnt_q : icnt_q + ISI_W'(1);
    is_burst = (32'(isi_inc) <= BURST_ISI);

    wcnt_d       = wcnt_q;
    scnt_d       = scnt_q;
    icnt_d       = icnt_q;
    have_prev_d  = have_prev_q;
    rate_d       = rate_q;
    rate_valid_d = rate_valid_q;
    overrun_d    = overrun_q;
    isi_d        = isi_q;
    isi_valid_d  = 1'b0;
    burst_d      = burst_q;

    if (clear_i) begin
      wcnt_d       = '0;
      scnt_d       = '0;
      icnt_d       = '0;
      have_prev_d  = 1'b0;
      rate_d       = '0;
      rate_valid_d = 1'b0;
      overrun_d    = 1'b0;
      isi_d        = '0;
      burst_d      = 1'b0;
    end else begin
      if (xfer) begin
        rate_valid_d = 1'b0;
      end
      if (ena) begin
        wcnt_d = wcnt_q + WINDOW_LOG2'(1);
        scnt_d = scnt_sum;
        if (&wcnt_q) begin
          rate_d       = scnt_sum;
          rate_valid_d = 1'b1;
          scnt_d       = '0;
          if (rate_valid_q && !xfer) begin
            overrun_d = 1'b1;
          end
        end
        if (spike_i) begin
          icnt_d      = '0;
          have_prev_d = 1'b1;
          if (have_prev_q) begin
            isi_d       = isi_inc;
            isi_valid_d = 1'b1;
            burst_d     = is_burst;
          end
        end else begin
          icnt_d = isi_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q       <= '0;
      scnt_q       <= '0;
      icnt_q       <= '0;
      have_prev_q  <= 1'b0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
      burst_q      <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      scnt_q       <= scnt_d;
      icnt_q       <= icnt_d;
      have_prev_q  <= have_prev_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
      burst_q      <= burst_d;
    end
  end

  assign rate_o       = rate_q;
  assign rate_valid_o = rate_valid_q;
  assign overrun_o    = overrun_q;
  assign isi_o        = isi_q;
  assign isi_valid_o  = isi_valid_q;
  assign burst_o      = burst_q;

endmodule
